// File: rtl/if_inst_queue.sv
// Instruction fetch queue between IF and ID: in-order FIFO of {PC, Inst, AdEL} with flush.
// Optional same-cycle IF->ID bypass when empty is enabled by defining IFQ_BYPASS_EN.
module if_inst_queue #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       Flush,
    input  logic                       IF_Valid,
    input  logic [31:0]                IF_PC,
    input  logic [31:0]                IF_Inst,
    output logic                       IF_Ready,
    output logic                       ID_Valid,
    input  logic                       ID_Ready,
    output logic [31:0]                ID_PC,
    output logic [31:0]                ID_Inst,
    output logic                       ID_AdEL,
    output logic [$clog2(DEPTH):0]     IFQ_Count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]       pc_mem   [DEPTH];
    logic [31:0]       inst_mem [DEPTH];
    logic [DEPTH-1:0]  adel_mem;
    logic [AW-1:0]     head_reg, tail_reg;
    logic [CW-1:0]     count_reg;

    logic full, empty, push, pop, bypass;
    logic [31:0] head_pc, head_inst;
    logic        head_adel;

    assign full      = (count_reg == CW'(DEPTH));
    assign empty     = (count_reg == '0);
    assign IF_Ready  = !full;
    assign IFQ_Count = count_reg;

    assign head_pc   = pc_mem[head_reg];
    assign head_inst = inst_mem[head_reg];
    assign head_adel = adel_mem[head_reg];

`ifdef IFQ_BYPASS_EN
    assign bypass = empty && IF_Valid && ID_Ready && !Flush;
`else
    assign bypass = 1'b0;
`endif

    // A bypassed instruction is consumed directly by ID and never stored.
    assign push = IF_Valid && IF_Ready && !Flush && !bypass;
    assign pop  = !empty && ID_Ready && !Flush;

    always_comb begin
        ID_Valid = !empty && !Flush;
        ID_PC    = head_pc;
        ID_AdEL  = head_adel;
        ID_Inst  = head_adel ? 32'h0 : head_inst;
        if (bypass) begin
            ID_Valid = 1'b1;
            ID_PC    = IF_PC;
            ID_AdEL  = |IF_PC[1:0];
            ID_Inst  = (|IF_PC[1:0]) ? 32'h0 : IF_Inst;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else if (Flush) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            if (push) tail_reg <= tail_reg + AW'(1);
            if (pop)  head_reg <= head_reg + AW'(1);
            if (push && !pop)      count_reg <= count_reg + CW'(1);
            else if (pop && !push) count_reg <= count_reg - CW'(1);
        end
    end

    // Entry contents survive a flush; only the pointers are rewound.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    pc_mem[gi]   <= '0;
                    inst_mem[gi] <= '0;
                    adel_mem[gi] <= 1'b0;
                end else if (push && (tail_reg == AW'(gi))) begin
                    pc_mem[gi]   <= IF_PC;
                    inst_mem[gi] <= IF_Inst;
                    adel_mem[gi] <= |IF_PC[1:0];
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_if_inst_queue.sv
// Directed self-checking bench for if_inst_queue (DEPTH = 4): reset, fill/drain,
// wrap-around streaming, flush, misaligned fetch and asynchronous reset.
module tb_if_inst_queue;
    logic        clk = 1'b0;
    logic        rst;
    logic        Flush, IF_Valid, IF_Ready, ID_Valid, ID_Ready, ID_AdEL;
    logic [31:0] IF_PC, IF_Inst, ID_PC, ID_Inst;
    logic [2:0]  IFQ_Count;

    int total = 0;
    int bad   = 0;

    if_inst_queue #(.DEPTH(4)) dut (
        .clk(clk), .rst(rst), .Flush(Flush),
        .IF_Valid(IF_Valid), .IF_PC(IF_PC), .IF_Inst(IF_Inst), .IF_Ready(IF_Ready),
        .ID_Valid(ID_Valid), .ID_Ready(ID_Ready), .ID_PC(ID_PC), .ID_Inst(ID_Inst),
        .ID_AdEL(ID_AdEL), .IFQ_Count(IFQ_Count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %-14s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; Flush = 1'b0; IF_Valid = 1'b0; ID_Ready = 1'b0;
        IF_PC = '0; IF_Inst = '0;
        #12;
        check("rst_count", 32'(IFQ_Count), 32'd0);
        check("rst_ifready", 32'(IF_Ready), 32'd1);
        check("rst_idvalid", 32'(ID_Valid), 32'd0);
        check("rst_idpc", ID_PC, 32'h0);
        check("rst_idinst", ID_Inst, 32'h0);
        check("rst_adel", 32'(ID_AdEL), 32'd0);
        rst = 1'b1;
        tick();

        // single push, visible one cycle later
        IF_Valid = 1'b1; IF_PC = 32'hBFC00000; IF_Inst = 32'h24080001;
        tick();
        IF_Valid = 1'b0;
        check("p1_valid", 32'(ID_Valid), 32'd1);
        check("p1_pc", ID_PC, 32'hBFC00000);
        check("p1_inst", ID_Inst, 32'h24080001);
        check("p1_count", 32'(IFQ_Count), 32'd1);
        ID_Ready = 1'b1;
        tick();
        ID_Ready = 1'b0;
        check("p1_popcount", 32'(IFQ_Count), 32'd0);
        check("p1_empty", 32'(ID_Valid), 32'd0);

`ifdef IFQ_BYPASS_EN
        IF_Valid = 1'b1; ID_Ready = 1'b1; IF_PC = 32'hBFC00000; IF_Inst = 32'h24080001;
        #1;
        check("byp_valid", 32'(ID_Valid), 32'd1);
        check("byp_pc", ID_PC, 32'hBFC00000);
        check("byp_inst", ID_Inst, 32'h24080001);
        tick();
        IF_Valid = 1'b0; ID_Ready = 1'b0;
        check("byp_count", 32'(IFQ_Count), 32'd0);
`endif

        // fill to full, fifth push dropped, drain in order
        for (int i = 0; i < 4; i++) begin
            IF_Valid = 1'b1; IF_PC = 32'h100 + 32'(4 * i); IF_Inst = 32'(i + 1);
            tick();
        end
        check("full_ready", 32'(IF_Ready), 32'd0);
        check("full_count", 32'(IFQ_Count), 32'd4);
        IF_PC = 32'h110;
        tick();
        IF_Valid = 1'b0;
        check("full_drop", 32'(IFQ_Count), 32'd4);
        ID_Ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("drain_pc", ID_PC, 32'h100 + 32'(4 * i));
            check("drain_inst", ID_Inst, 32'(i + 1));
            tick();
        end
        ID_Ready = 1'b0;
        check("drain_count", 32'(IFQ_Count), 32'd0);
        check("drain_valid", 32'(ID_Valid), 32'd0);

        // streaming at count 2 across pointer wrap
        for (int i = 0; i < 2; i++) begin
            IF_Valid = 1'b1; IF_PC = 32'h200 + 32'(4 * i); IF_Inst = 32'hA0 + 32'(i);
            tick();
        end
        ID_Ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            IF_Valid = 1'b1; IF_PC = 32'h208 + 32'(4 * k);
            @(negedge clk);
            check("wrap_pc", ID_PC, 32'h200 + 32'(4 * k));
            check("wrap_count", 32'(IFQ_Count), 32'd2);
            tick();
        end
        IF_Valid = 1'b0;
        check("wrap_end_pc", ID_PC, 32'h228);
        tick();
        tick();
        ID_Ready = 1'b0;
        check("wrap_drained", 32'(IFQ_Count), 32'd0);

        // flush at count 3 with coincident push and pop
        for (int i = 0; i < 3; i++) begin
            IF_Valid = 1'b1; IF_PC = 32'h300 + 32'(4 * i); IF_Inst = 32'hB0;
            tick();
        end
        Flush = 1'b1; IF_Valid = 1'b1; IF_PC = 32'h30C; ID_Ready = 1'b1;
        @(negedge clk);
        check("flush_valid", 32'(ID_Valid), 32'd0);
        tick();
        Flush = 1'b0; IF_Valid = 1'b0; ID_Ready = 1'b0;
        check("flush_count", 32'(IFQ_Count), 32'd0);
        check("flush_idvalid", 32'(ID_Valid), 32'd0);
        IF_Valid = 1'b1; IF_PC = 32'h400; IF_Inst = 32'hC0;
        tick();
        IF_Valid = 1'b0;
        check("post_flush_pc", ID_PC, 32'h400);
        check("post_flush_cnt", 32'(IFQ_Count), 32'd1);
        ID_Ready = 1'b1;
        tick();
        ID_Ready = 1'b0;

        // misaligned fetch address
        IF_Valid = 1'b1; IF_PC = 32'h00400002; IF_Inst = 32'hFFFFFFFF;
        tick();
        IF_Valid = 1'b0;
        check("adel_flag", 32'(ID_AdEL), 32'd1);
        check("adel_inst", ID_Inst, 32'h0);
        check("adel_pc", ID_PC, 32'h00400002);
        ID_Ready = 1'b1;
        tick();
        ID_Ready = 1'b0;

        // asynchronous reset between edges at count 3
        for (int i = 0; i < 3; i++) begin
            IF_Valid = 1'b1; IF_PC = 32'h500 + 32'(4 * i); IF_Inst = 32'hD0;
            tick();
        end
        IF_Valid = 1'b0;
        check("pre_arst_cnt", 32'(IFQ_Count), 32'd3);
        #2 rst = 1'b0;
        #1;
        check("arst_count", 32'(IFQ_Count), 32'd0);
        check("arst_valid", 32'(ID_Valid), 32'd0);
        check("arst_ready", 32'(IF_Ready), 32'd1);
        check("arst_pc", ID_PC, 32'h0);
        check("arst_inst", ID_Inst, 32'h0);
        #1 rst = 1'b1;
        IF_Valid = 1'b1; IF_PC = 32'h600; IF_Inst = 32'hE0;
        tick();
        IF_Valid = 1'b0;
        check("rel_count", 32'(IFQ_Count), 32'd1);
        check("rel_pc", ID_PC, 32'h600);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/if_inst_queue.md
# if_inst_queue

Instruction fetch queue between the PC/instruction-fetch stage and the decode stage. It captures each fetched PC and instruction word from the I-side memory response, tags address-error exceptions, and presents entries in order to ID with a valid/ready handshake. Its full status backpressures fetch: IF_Ready feeds the PC write-enable. A single-cycle flush discards all buffered entries on branch redirect or exception.

## Interface
- DEPTH, 4: number of entries; must be a power of two and at least 2.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- Flush  input  1  discards all entries; wins over every other event in the same cycle.
- IF_Valid  input  1  IF_PC/IF_Inst hold a fetched instruction this cycle.
- IF_PC  input  32  PC of the fetched instruction.
- IF_Inst  input  32  fetched instruction word.
- IF_Ready  output  1  queue can accept; equals !Full; drives PC_Wr gating upstream.
- ID_Valid  output  1  ID_PC/ID_Inst/ID_AdEL hold the head entry.
- ID_Ready  input  1  decode consumes the head this cycle when ID_Valid is high.
- ID_PC  output  32  head entry PC.
- ID_Inst  output  32  head entry instruction; forced to 32'h0 when ID_AdEL is 1.
- ID_AdEL  output  1  head entry has a misaligned fetch address (PC[1:0] != 2'b00).
- IFQ_Count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.

## Operation
- Storage: DEPTH entries of {PC[31:0], Inst[31:0], AdEL}, with head and tail pointers of $clog2(DEPTH) bits that wrap modulo DEPTH, plus an occupancy counter.
- Push occurs when IF_Valid && IF_Ready && !Flush. The entry is written at tail, tail advances, and AdEL = |IF_PC[1:0].
- Pop occurs when ID_Valid && ID_Ready && !Flush. Head advances.
- Push and pop together: count unchanged, both pointers advance. This is legal at any count from 1 to DEPTH-1.
- Full (count == DEPTH): IF_Ready = 0 and any IF_Valid is ignored. A pop in the same cycle does not enable a push, so IF_Ready has no combinational dependence on ID_Ready.
- Empty (count == 0): ID_Valid = 0, and ID_PC/ID_Inst show the stale head slot. An ID_Ready with no valid entry has no effect.
- Flush: next cycle head = tail = 0 and count = 0. Entry contents are not cleared. Any push or pop in the flush cycle is dropped. While Flush is high, ID_Valid is forced to 0.
- Ordering is strict FIFO, with no reordering or merging.

## Timing
- Reset (rst = 0, asynchronous) gives: count 0, pointers 0, all entries 0, IF_Ready 1, ID_Valid 0, ID_PC 0, ID_Inst 0, ID_AdEL 0, IFQ_Count 0.
- Base latency: an instruction pushed in cycle N appears at ID with ID_Valid = 1 in cycle N+1.
- ID outputs are read combinationally from the head slot. IF_Ready and IFQ_Count depend only on registered state.
- Throughput is one push and one pop per cycle at steady state.
- Releasing reset in the middle of a stream: the first IF_Valid seen after rst goes high is pushed on the following clock edge.

## Configuration
- IFQ_BYPASS_EN defined:
  - Applies when count == 0, IF_Valid = 1, ID_Ready = 1 and Flush = 0.
  - IF data passes combinationally to ID in the same cycle: ID_Valid = 1, ID_PC = IF_PC, ID_AdEL = |IF_PC[1:0], ID_Inst = IF_Inst, or 0 when AdEL.
  - Nothing is written in that cycle and count stays 0.
  - When empty with ID_Ready = 0, the queue pushes normally.
- IFQ_BYPASS_EN undefined:
  - No combinational path exists from IF inputs to ID outputs.
  - Minimum latency is 1 cycle.

## Test plan
- Reset then single push: rst low→high, push IF_PC = 32'hBFC00000, IF_Inst = 32'h24080001 → next cycle ID_Valid = 1 with the same PC and Inst, IFQ_Count = 1. With IFQ_BYPASS_EN and ID_Ready = 1, these appear in the same cycle and count stays 0.
- Fill to full with DEPTH = 4 and ID_Ready = 0: push PCs 0x100, 0x104, 0x108, 0x10C → IF_Ready = 0, IFQ_Count = 4. A fifth IF_Valid with PC 0x110 is dropped. Draining then yields 0x100..0x10C in order.
- Wrap-around: 10 cycles of simultaneous push and pop at count = 2 → count stays 2 and the ID_PC sequence is strictly increasing by 4 across pointer wrap.
- Flush with a coincident push and pop, at count = 3 → ID_Valid = 0 during the Flush cycle, next cycle IFQ_Count = 0, and the pushed PC never appears at ID.
- Misaligned fetch: push IF_PC = 32'h00400002, IF_Inst = 32'hFFFFFFFF → at the head, ID_AdEL = 1, ID_Inst = 0, ID_PC = 32'h00400002.
- Asynchronous reset mid-stream: assert rst between clock edges with count = 3 → outputs go to reset values immediately, without waiting for a clock edge.
